// File: rtl/pakin_chk.sv
// Packet sink and checker. Accepts packets over a 4-phase req/ack channel
// whose request may come from an unrelated clock. Each packet's address range,
// redundancy nibble and data sequence are checked. Saturating statistics are
// kept and shown on a small debug link (case select in; leds/digits out).
module pakin_chk #(
    parameter int ASZ      = 6,
    parameter int DSZ      = 4,
    parameter int RSZ      = 4,
    parameter int PSZ      = ASZ + DSZ + RSZ,
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 14,
    parameter int CSZ      = 8
) (
    input  logic           i_clk,
    input  logic           reset,
    input  logic           rcv0_req,
    input  logic [PSZ-1:0] rcv0_data,
    output logic           rcv0_ack,
    input  logic [7:0]     dbg_case,
    input  logic           dbg_doit,
    output logic [3:0]     dbg_leds,
    output logic [3:0]     dbg_disp0,
    output logic [3:0]     dbg_disp1
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [ASZ-1:0] MIN_A = MIN_ADDR[ASZ-1:0];
    localparam logic [ASZ-1:0] MAX_A = MAX_ADDR[ASZ-1:0];

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CSZ-1:0] sat_inc(input logic [CSZ-1:0] v);
        return (&v) ? v : v + CSZ'(1);
    endfunction

    logic           s1_q, s2_q;
    logic [1:0]     state_q, state_d;
    logic           ack_q, ack_d;
    logic [PSZ-1:0] pak_q, pak_d;
    logic [DSZ-1:0] exp_q, exp_d;
    logic [CSZ-1:0] pak_cnt_q, pak_cnt_d;
    logic [CSZ-1:0] err_addr_q, err_addr_d;
    logic [CSZ-1:0] err_red_q, err_red_d;
    logic [CSZ-1:0] err_seq_q, err_seq_d;
    logic [3:0]     leds_q, leds_d;
    logic [3:0]     disp0_q, disp0_d;
    logic [3:0]     disp1_q, disp1_d;

    // Field split of the captured packet: {addr, data, redun}, addr in MSBs.
    logic [ASZ-1:0] pak_addr;
    logic [DSZ-1:0] pak_data;
    logic [RSZ-1:0] pak_red;
    logic           addr_ok, red_ok, seq_ok;

    assign pak_addr = pak_q[PSZ-1 -: ASZ];
    assign pak_data = pak_q[RSZ +: DSZ];
    assign pak_red  = pak_q[RSZ-1:0];
    assign addr_ok  = (pak_addr >= MIN_A) && (pak_addr <= MAX_A);
    assign red_ok   = (pak_red == (pak_addr[RSZ-1:0] ^ pak_data[RSZ-1:0]));
    assign seq_ok   = (pak_data == exp_q);

    // Two-flop synchroniser for the foreign-clock request.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= rcv0_req;
            s2_q <= s1_q;
        end
    end

    // Handshake FSM and packet checks; counters only move in CHECK.
    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        pak_d      = pak_q;
        exp_d      = exp_q;
        pak_cnt_d  = pak_cnt_q;
        err_addr_d = err_addr_q;
        err_red_d  = err_red_q;
        err_seq_d  = err_seq_q;
        case (state_q)
            ST_IDLE: begin
                if (s2_q && !ack_q) begin
                    pak_d   = rcv0_data;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                pak_cnt_d = sat_inc(pak_cnt_q);
                if (!addr_ok) err_addr_d = sat_inc(err_addr_q);
                if (!red_ok)  err_red_d  = sat_inc(err_red_q);
                if (addr_ok && red_ok) begin
                    // Any well-formed packet resynchronises the expected sequence.
                    if (!seq_ok) err_seq_d = sat_inc(err_seq_q);
                    exp_d = pak_data + DSZ'(1);
                end
                ack_d   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!s2_q) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and statistics registers.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            pak_q      <= '0;
            exp_q      <= '0;
            pak_cnt_q  <= '0;
            err_addr_q <= '0;
            err_red_q  <= '0;
            err_seq_q  <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            pak_q      <= pak_d;
            exp_q      <= exp_d;
            pak_cnt_q  <= pak_cnt_d;
            err_addr_q <= err_addr_d;
            err_red_q  <= err_red_d;
            err_seq_q  <= err_seq_d;
        end
    end

    // Low byte of each counter, as shown on the two digits.
    logic [7:0] pak_cnt8, err_addr8, err_red8, err_seq8;
    logic [3:0] err_leds, state_leds;

    assign pak_cnt8   = 8'(pak_cnt_q);
    assign err_addr8  = 8'(err_addr_q);
    assign err_red8   = 8'(err_red_q);
    assign err_seq8   = 8'(err_seq_q);
    assign err_leds   = {(err_seq_q != '0), (err_red_q != '0), (err_addr_q != '0), 1'b1};
    assign state_leds = {ack_q, (state_q == ST_WAIT), (state_q == ST_CHECK), (state_q == ST_IDLE)};

    // Debug view selection.
    always_comb begin
        leds_d  = 4'd0;
        disp0_d = 4'd0;
        disp1_d = 4'd0;
        case (dbg_case)
            8'd0: begin
                leds_d  = state_leds;
                disp0_d = pak_cnt8[7:4];
                disp1_d = pak_cnt8[3:0];
            end
            8'd1: begin
                leds_d  = err_leds;
                disp0_d = err_addr8[7:4];
                disp1_d = err_addr8[3:0];
            end
            8'd2: begin
                leds_d  = err_leds;
                disp0_d = err_red8[7:4];
                disp1_d = err_red8[3:0];
            end
            8'd3: begin
                leds_d  = err_leds;
                disp0_d = err_seq8[7:4];
                disp1_d = err_seq8[3:0];
            end
            8'd4: begin
                leds_d  = err_leds;
                disp0_d = 4'(pak_addr);
                disp1_d = 4'(pak_data);
            end
            default: ;
        endcase
    end

    // Debug outputs refresh every cycle unless frozen by dbg_doit.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            leds_q  <= 4'd0;
            disp0_q <= 4'd0;
            disp1_q <= 4'd0;
        end else if (!dbg_doit) begin
            leds_q  <= leds_d;
            disp0_q <= disp0_d;
            disp1_q <= disp1_d;
        end
    end

    assign rcv0_ack  = ack_q;
    assign dbg_leds  = leds_q;
    assign dbg_disp0 = disp0_q;
    assign dbg_disp1 = disp1_q;

endmodule

// File: tb/tb_pakin_chk.sv
// Bench for pakin_chk: a driver runs 4-phase handshakes and pushes the
// expected ack edge latencies into a queue; a monitor measures the real ack
// edges and compares. Statistics are read back through the debug link and
// compared with a simple counting model of the checking rules.
module tb_pakin_chk;

    logic        clk = 1'b0;
    logic        rst;
    logic        rcv0_req;
    logic [13:0] rcv0_data;
    logic        rcv0_ack;
    logic [7:0]  dbg_case;
    logic        dbg_doit;
    logic [3:0]  dbg_leds, dbg_disp0, dbg_disp1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit rise;
        int lat;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state
    int m_pak, m_ea, m_er, m_es, m_exp, m_la, m_ld;

    pakin_chk dut (
        .i_clk     (clk),
        .reset     (rst),
        .rcv0_req  (rcv0_req),
        .rcv0_data (rcv0_data),
        .rcv0_ack  (rcv0_ack),
        .dbg_case  (dbg_case),
        .dbg_doit  (dbg_doit),
        .dbg_leds  (dbg_leds),
        .dbg_disp0 (dbg_disp0),
        .dbg_disp1 (dbg_disp1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_pak = 0; m_ea = 0; m_er = 0; m_es = 0; m_exp = 0; m_la = 0; m_ld = 0;
    endtask

    task automatic model_pkt(input int a, input int d, input int r);
        bit aok, rok;
        aok = (a >= 1) && (a <= 14);
        rok = (r == ((a % 16) ^ d));
        m_pak = sat(m_pak);
        if (!aok) m_ea = sat(m_ea);
        if (!rok) m_er = sat(m_er);
        if (aok && rok) begin
            if (d != m_exp) m_es = sat(m_es);
            m_exp = (d + 1) % 16;
        end
        m_la = a % 16;
        m_ld = d;
    endtask

    // Expected {leds, disp0, disp1} for an idle DUT and a given case select.
    function automatic logic [11:0] exp_dbg(input int c);
        logic [3:0] el;
        el = {m_es != 0, m_er != 0, m_ea != 0, 1'b1};
        case (c)
            0: return {4'b0001, 8'(m_pak)};
            1: return {el, 8'(m_ea)};
            2: return {el, 8'(m_er)};
            3: return {el, 8'(m_es)};
            4: return {el, 4'(m_la), 4'(m_ld)};
            default: return 12'd0;
        endcase
    endfunction

    // Monitor: counts edges since the last req change (or reset release)
    // and checks each ack edge against the scoreboard.
    bit req_seen = 1'b0, ack_seen = 1'b0;
    int edge_cnt = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            req_seen = 1'b0;
            ack_seen = 1'b0;
            edge_cnt = 0;
        end else begin
            if (rcv0_req != req_seen) begin
                req_seen = rcv0_req;
                edge_cnt = 1;
            end else begin
                edge_cnt++;
            end
            if (rcv0_ack != ack_seen) begin
                ack_seen = rcv0_ack;
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL ack_edge: unexpected ack=%0b after %0d edges", rcv0_ack, edge_cnt);
                end else begin
                    e = sb_q.pop_front();
                    if (e.rise != rcv0_ack || e.lat != edge_cnt) begin
                        miscompares++;
                        $display("FAIL ack_edge: got ack=%0b after %0d edges expected ack=%0b after %0d",
                                 rcv0_ack, edge_cnt, e.rise, e.lat);
                    end else begin
                        $display("ack=%0b after %0d edges ok", rcv0_ack, edge_cnt);
                    end
                end
            end
        end
    end

    task automatic wait_ack(input logic lvl, input string nm);
        int n = 0;
        while (rcv0_ack !== lvl && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, rcv0_ack}, {31'd0, lvl});
    endtask

    // One full handshake; req held for 'hold' extra cycles after ack rises.
    task automatic send(input int a, input int d, input int r, input int hold);
        exp_t e;
        @(negedge clk);
        rcv0_data = {6'(a), 4'(d), 4'(r)};
        rcv0_req  = 1'b1;
        e.rise = 1'b1; e.lat = 4; sb_q.push_back(e);
        model_pkt(a, d, r);
        wait_ack(1'b1, "ack_rise_timeout");
        repeat (hold) @(negedge clk);
        rcv0_req = 1'b0;
        e.rise = 1'b0; e.lat = 3; sb_q.push_back(e);
        wait_ack(1'b0, "ack_fall_timeout");
        $display("pkt addr=%0d data=%0d red=%0d -> pak=%0d ea=%0d er=%0d es=%0d",
                 a, d, r, m_pak, m_ea, m_er, m_es);
    endtask

    task automatic check_dbg(input int c);
        @(negedge clk);
        dbg_case = 8'(c);
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("dbg_case%0d", c), {20'd0, dbg_leds, dbg_disp0, dbg_disp1}, {20'd0, exp_dbg(c)});
    endtask

    task automatic check_all();
        check_dbg(0); check_dbg(1); check_dbg(2);
        check_dbg(3); check_dbg(4); check_dbg(9);
    endtask

    initial begin
        logic [11:0] frozen;
        exp_t e;
        int a, d, r;
        rst = 1'b1; rcv0_req = 1'b0; rcv0_data = '0; dbg_case = 8'd0; dbg_doit = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_ack", {31'd0, rcv0_ack}, 32'd0);
        chk("reset_dbg", {20'd0, dbg_leds, dbg_disp0, dbg_disp1}, 32'd0);
        rst = 1'b0;
        check_dbg(0);

        // In-sequence packets
        send(5, 0, 5, 0);
        send(5, 1, 4, 0);
        send(5, 2, 7, 0);
        check_all();
        // Out-of-range addresses
        send(0, 3, 3, 0);
        send(15, 3, 12, 0);
        check_dbg(1);
        // Bad redundancy
        send(5, 3, 0, 0);
        check_dbg(2);
        check_dbg(3);
        // Sequence skip then resync
        send(5, 3, 6, 0);
        send(5, 7, 2, 0);
        send(5, 8, 13, 0);
        check_all();
        // Long-held request counts once
        send(6, 9, 15, 50);
        check_dbg(0);

        // Frozen debug outputs do not follow the counters
        check_dbg(0);
        frozen = exp_dbg(0);
        @(negedge clk);
        dbg_doit = 1'b1;
        send(7, 10, 13, 2);
        repeat (2) @(negedge clk);
        chk("dbg_frozen", {20'd0, dbg_leds, dbg_disp0, dbg_disp1}, {20'd0, frozen});
        dbg_doit = 1'b0;
        check_dbg(0);

        // Random traffic, long enough to saturate the packet counter
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
            d = ($urandom_range(0, 1) == 0) ? m_exp : int'($urandom_range(0, 15));
            r = ($urandom_range(0, 3) != 0) ? ((a % 16) ^ d) : int'($urandom_range(0, 15));
            send(a, d, r, int'($urandom_range(0, 3)));
            if (i % 50 == 49) check_all();
        end
        check_all();

        // Reset in WAIT_LO with req held: ack drops at once, packet re-accepted
        @(negedge clk);
        rcv0_data = {6'd5, 4'd9, 4'd12};
        rcv0_req  = 1'b1;
        e.rise = 1'b1; e.lat = 4; sb_q.push_back(e);
        wait_ack(1'b1, "ack_rise_timeout");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_async_ack", {31'd0, rcv0_ack}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        e.rise = 1'b1; e.lat = 4; sb_q.push_back(e);
        model_pkt(5, 9, 12);
        wait_ack(1'b1, "ack_rise_timeout");
        @(negedge clk);
        rcv0_req = 1'b0;
        e.rise = 1'b0; e.lat = 3; sb_q.push_back(e);
        wait_ack(1'b0, "ack_fall_timeout");
        check_all();

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pakin_chk.md
Name: pakin_chk

Overview:
- Packet sink and checker; sits directly downstream of the packet source channel and consumes its packets.
- Receives packets over a 4-phase req/ack channel, possibly from a slower or unrelated source clock, and validates each packet's address range, redundancy field and data sequence.
- Keeps saturating statistics counters and exposes them on the standard debug link (case select in; leds/disp0/disp1 out) for board bring-up.

Parameters:
- ASZ, 6, address field width.
- DSZ, 4, data field width.
- RSZ, 4, redundancy field width (RSZ <= DSZ, RSZ <= ASZ).
- PSZ, ASZ+DSZ+RSZ, packet width; layout {addr[ASZ], data[DSZ], redun[RSZ]}, addr in MSBs.
- MIN_ADDR, 1, lowest legal address.
- MAX_ADDR, 14, highest legal address.
- CSZ, 8, statistics counter width.

Ports:
- i_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- rcv0_req  in  1  source request; asynchronous to i_clk.
- rcv0_data  in  PSZ  packet; stable while rcv0_req=1.
- rcv0_ack  out  1  sink acknowledge, registered.
- dbg_case  in  8  debug case select.
- dbg_doit  in  1  level; when 1, debug outputs freeze.
- dbg_leds  out  4  debug LEDs.
- dbg_disp0  out  4  debug digit, high nibble.
- dbg_disp1  out  4  debug digit, low nibble.

Behaviour:
- Reset: async assert, released synchronously to i_clk.
  - rcv0_ack=0; state IDLE.
  - All counters = 0; expected sequence exp_data=0.
  - dbg_leds=0, dbg_disp0=0, dbg_disp1=0.
- rcv0_req synchroniser: 2-flop chain s1, s2. Only s2 is used; rcv0_data is sampled only when s2=1.
- IDLE:
  - s2=1 and ack=0: capture rcv0_data into pak_r, go to CHECK.
  - Otherwise stay in IDLE.
- CHECK (one cycle):
  - addr_ok = MIN_ADDR <= addr <= MAX_ADDR.
  - red_ok = redun equals addr[RSZ-1:0] XOR data[RSZ-1:0].
  - seq_ok = data equals exp_data.
  - Always: pak_cnt++.
  - If !addr_ok: err_addr++. If !red_ok: err_red++.
  - If addr_ok and red_ok and !seq_ok: err_seq++.
  - If addr_ok and red_ok: exp_data <= data+1 (mod 2^DSZ), i.e. resync on any valid packet.
  - Set rcv0_ack<=1; go to WAIT_LO.
- WAIT_LO:
  - s2=0: rcv0_ack<=0, go to IDLE.
  - s2=1: hold ack high.
- Latency: req rises before edge E1 → s2=1 after E2 → capture at E3 → ack high after E4 (4 edges). Ack falls 3 edges after req falls.
- Counters saturate at 2^CSZ-1; never wrap.
- One packet per handshake. A req that stays high never double-counts; ack stays high until req drops.
- Reset mid-handshake: ack drops immediately (async). If req is still high after reset release, the packet is accepted again as a new packet.
- Debug mux, registered every cycle while dbg_doit=0; held while dbg_doit=1.
  - case 0: disp0/disp1 = pak_cnt[7:4]/[3:0]; leds = state one-hot {WAIT_LO, CHECK, IDLE} plus bit3 = rcv0_ack.
  - case 1: err_addr nibbles on disp0/disp1.
  - case 2: err_red nibbles on disp0/disp1.
  - case 3: err_seq nibbles on disp0/disp1.
  - case 4: last pak_r addr[3:0]/data on disp0/disp1.
  - Cases 1–4: leds = {err_seq!=0, err_red!=0, err_addr!=0, 1}.
  - Other cases: all debug outputs 0.
- Counter bits above [7:0] are not shown when CSZ > 8.

Test Plan:
- After reset, send 3 packets with addr=5 and data 0,1,2 (redun = addr XOR data), each as a full 4-phase handshake → ack rises 4 edges after each req; pak_cnt=3; all error counters 0; case 0 shows disp 0/3.
- Send addr=0 then addr=15, each with data 3 and correct redun → err_addr=2; exp_data unchanged; case 1 shows 0/2, leds=4'b0011.
- Send addr=5, data=3, redun=0 → err_red=1; err_seq unchanged.
- Skip sequence: send data 3 then data 7, both valid → err_seq=1; exp_data=8.
- Hold req high for 50 cycles → exactly one count; ack stays high until 3 edges after req falls.
- Assert reset while in WAIT_LO with req still high → ack=0 at once; after release the packet is re-accepted: pak_cnt=1, ack high 4 edges later.
